pattern_lut_cclut_loader: RTL and testbench
===========================================

Name: pattern_lut_cclut_loader

Overview:
Write-side companion to the CCLUT pattern lookup. It streams 18-bit comparator-code LUT words into the per-pattern RAM tables through a valid/ready input and a registered RAM write port. The tables are addressed by pattern ID (6..A) and 12-bit comparator code. The block range-checks each load request and tracks the word count and a checksum for readback verification. It sits between the VME/slow-control register block and the RAM-based pattern LUTs.

Parameters:
MXADRB, 12, LUT address (comparator code) width
MXDATB, 18, LUT word width; bits [8:5] are the offset, bits [4:0] are the bend
MXPIDB, 4, pattern ID width
PID_MIN, 6, lowest valid pattern ID
PID_MAX, 10, highest valid pattern ID (hA)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle load request
start_pid  in  MXPIDB  target pattern ID
start_adr  in  MXADRB  first LUT address
nwords  in  MXADRB+1  number of words to load (0..4096)
din  in  MXDATB  LUT data word
din_vld  in  1  din valid
din_rdy  out  1  loader accepts din
abort  in  1  cancel the load in progress
wr_en  out  1  RAM write strobe
wr_pid  out  MXPIDB  RAM table select
wr_adr  out  MXADRB  RAM address
wr_dat  out  MXDATB  RAM data
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse (success or error)
err  out  1  last load failed; held until the next accepted start
err_code  out  2  1 = bad PID, 2 = address overflow, 3 = aborted, 0 = none
wcount  out  MXADRB+1  words written in the current/last load
checksum  out  16  running sum over accepted words, mod 2^16

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-load stops all writes from the next cycle, produces no done pulse, and discards the remaining count.
- States: IDLE, CHECK, LOAD, FLUSH, FIN.
- IDLE:
  - start latches pid, adr and nwords; clears err, err_code, wcount and checksum; next state CHECK.
  - start is ignored outside IDLE.
  - abort is ignored in IDLE; start wins if both are asserted.
- CHECK (1 cycle):
  - pid < PID_MIN or pid > PID_MAX: err = 1, code 1, go to FIN.
  - Otherwise, adr + nwords > 4096: err = 1, code 2, go to FIN.
  - Otherwise, nwords == 0: go to FIN with no error and no writes.
  - Otherwise go to LOAD.
  - abort in CHECK: code 3, go to FIN. abort takes priority over the range checks.
- din_rdy is combinational: (state == LOAD) & ~abort & (remaining != 0).
- Accept = din_vld & din_rdy. On each accept, in the next cycle:
  - wr_en = 1, wr_dat = din, wr_pid = latched pid, wr_adr = current address.
  - The address increments by 1; remaining decrements by 1; wcount increments by 1.
  - checksum += din[15:0] + din[17:16], wrapping mod 2^16.
- wr_en is low in every cycle not preceded by an accept. Address wrap cannot occur, because overflow is rejected in CHECK.
- Latency: 1 cycle from accept to wr_en.
- LOAD:
  - The last accept (remaining becomes 0) at cycle N gives FLUSH at N+1, with the final wr_en in that cycle.
  - FIN is at N+2, with done = 1 for exactly one cycle.
  - IDLE at N+3.
- abort in LOAD: go to FIN next cycle with err = 1, code 3.
  - A word accepted in the cycle before abort is still written, in the abort cycle.
  - No word is accepted in the abort cycle.
- FIN: done = 1, next state IDLE. err, err_code, wcount and checksum hold until the next start.
- wr_pid, wr_adr and wr_dat hold their last values when wr_en = 0.

Test Plan:
1. Basic load: pid 6, adr 0, nwords 4, din 1,2,3,4 back-to-back with din_vld held high -> wr_en high for 4 consecutive cycles, each 1 cycle after its accept; wr_adr 0,1,2,3; wr_pid 6; checksum 10; wcount 4; done 2 cycles after the last accept; err 0.
2. Bad PID: pid 5, then separately pid 11 -> no wr_en; din_rdy never high; done pulse 2 cycles after start; err 1, err_code 1.
3. Address overflow: pid A, adr 4094, nwords 3 -> err_code 2, no writes. Same request with nwords 2 -> writes to 4094 and 4095, err 0.
4. Gapped input: nwords 3, din_vld pattern 1,0,0,1,0,1, data 3FFFF, x, x, 1, x, 0 -> wr_adr contiguous; exactly 3 writes; checksum 0x0003 (0xFFFF + 3 + 1 + 0 mod 2^16).
5. Abort: nwords 5, abort asserted while the 3rd word is offered -> exactly 2 writes; the 3rd word is not accepted; err_code 3; wcount 2; done pulse. Abort in IDLE has no effect.
6. Reset mid-load after 1 write, then a new start with pid 7, adr 100, nwords 1 -> no done pulse for the interrupted load; the new load writes adr 100 only; wcount 1; err 0.

Source files
------------

// File: rtl/pattern_lut_cclut_loader.sv
// Streams comparator-code LUT words into the per-pattern RAM tables.
// Range-checks each load request and keeps the word count and checksum for readback.
module pattern_lut_cclut_loader #(
  parameter int MXADRB  = 12,
  parameter int MXDATB  = 18,
  parameter int MXPIDB  = 4,
  parameter int PID_MIN = 6,
  parameter int PID_MAX = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [MXPIDB-1:0] start_pid,
  input  logic [MXADRB-1:0] start_adr,
  input  logic [MXADRB:0]   nwords,
  input  logic [MXDATB-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  input  logic              abort,
  output logic              wr_en,
  output logic [MXPIDB-1:0] wr_pid,
  output logic [MXADRB-1:0] wr_adr,
  output logic [MXDATB-1:0] wr_dat,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [MXADRB:0]   wcount,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {IDLE, CHECK, LOAD, FLUSH, FIN} state_t;

  localparam logic [MXPIDB-1:0] PID_LO   = MXPIDB'(PID_MIN);
  localparam logic [MXPIDB-1:0] PID_HI   = MXPIDB'(PID_MAX);
  localparam logic [MXADRB+1:0] ADR_SPAN = {2'b01, {MXADRB{1'b0}}};

  state_t              state;
  logic [MXPIDB-1:0]   pid;
  logic [MXADRB-1:0]   adr;
  logic [MXADRB:0]     remaining;
  logic [MXADRB+1:0]   end_adr;
  logic                accept;

  assign din_rdy = (state == LOAD) && !abort && (remaining != '0);
  assign accept  = din_vld && din_rdy;
  assign busy    = (state != IDLE);
  // One bit wider than the table so first+count == table size is still representable.
  assign end_adr = {2'b00, adr} + {1'b0, remaining};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pid       <= '0;
      adr       <= '0;
      remaining <= '0;
      wr_en     <= 1'b0;
      wr_pid    <= '0;
      wr_adr    <= '0;
      wr_dat    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      wcount    <= '0;
      checksum  <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;

      if (accept) begin
        wr_en     <= 1'b1;
        wr_dat    <= din;
        wr_pid    <= pid;
        wr_adr    <= adr;
        adr       <= adr + 1'b1;
        remaining <= remaining - 1'b1;
        wcount    <= wcount + 1'b1;
        checksum  <= checksum + din[15:0] + 16'(din[17:16]);
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            pid       <= start_pid;
            adr       <= start_adr;
            remaining <= nwords;
            err       <= 1'b0;
            err_code  <= '0;
            wcount    <= '0;
            checksum  <= '0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (abort) begin
            err      <= 1'b1;
            err_code <= 2'd3;
            done     <= 1'b1;
            state    <= FIN;
          end else if (pid < PID_LO || pid > PID_HI) begin
            err      <= 1'b1;
            err_code <= 2'd1;
            done     <= 1'b1;
            state    <= FIN;
          end else if (end_adr > ADR_SPAN) begin
            err      <= 1'b1;
            err_code <= 2'd2;
            done     <= 1'b1;
            state    <= FIN;
          end else if (remaining == '0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            err      <= 1'b1;
            err_code <= 2'd3;
            done     <= 1'b1;
            state    <= FIN;
          end else if (accept && remaining == {{MXADRB{1'b0}}, 1'b1}) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_lut_cclut_loader.sv
// Bench for pattern_lut_cclut_loader: table-driven loads with a write scoreboard,
// plus hand-written reset-mid-load and abort corner sequences.
module tb_pattern_lut_cclut_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  start_pid;
  logic [11:0] start_adr;
  logic [12:0] nwords;
  logic [17:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic        abort;
  logic        wr_en;
  logic [3:0]  wr_pid;
  logic [11:0] wr_adr;
  logic [17:0] wr_dat;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [12:0] wcount;
  logic [15:0] checksum;

  pattern_lut_cclut_loader #(
    .MXADRB(12), .MXDATB(18), .MXPIDB(4), .PID_MIN(6), .PID_MAX(10)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .start_pid(start_pid),
    .start_adr(start_adr), .nwords(nwords), .din(din), .din_vld(din_vld),
    .din_rdy(din_rdy), .abort(abort), .wr_en(wr_en), .wr_pid(wr_pid),
    .wr_adr(wr_adr), .wr_dat(wr_dat), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .wcount(wcount), .checksum(checksum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]       pid;
    logic [11:0]      adr;
    logic [12:0]      nw;
    logic [15:0]      vld_pat;
    int               abort_at;
    logic [3:0][17:0] dat;
    logic             exp_err;
    logic [1:0]       exp_code;
    logic [12:0]      exp_wcount;
    logic [15:0]      exp_sum;
  } vec_t;

  typedef struct {
    logic [3:0]  pid;
    logic [11:0] adr;
    logic [17:0] dat;
    int          cyc;
  } wr_t;

  localparam logic [3:0][17:0] DFLT = {18'd4, 18'd3, 18'd2, 18'd1};

  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  obs_rd = 0;
  int  pass_cnt = 0;
  int  total_cnt = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];
  vec_t vecs[12];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (wr_en) obs_q.push_back('{wr_pid, wr_adr, wr_dat, cyc});
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [17:0] word(input vec_t v, input int k);
    return (k < 4) ? v.dat[k] : 18'(k + 1);
  endfunction

  task automatic run_load(input vec_t v, input int id);
    int k = 0, c0, last_acc = -1, abort_cyc = -1, dstart, exp_done;
    bit aborted = 0;
    string tag = $sformatf("v%0d", id);
    exp_q.delete();
    dstart = done_cnt;
    @(posedge clock); #1;
    start = 1'b1; start_pid = v.pid; start_adr = v.adr; nwords = v.nw; c0 = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    for (int t = 0; t < 200 && done_cnt == dstart; t++) begin
      @(posedge clock); #1;
      din_vld = !aborted && (13'(k) < v.nw) && (t >= 16 || v.vld_pat[t]);
      din     = din_vld ? word(v, k) : 18'($urandom);
      abort   = din_vld && (k == v.abort_at);
      @(negedge clock);
      if (din_vld && din_rdy) begin
        exp_q.push_back('{v.pid, v.adr + 12'(k), din, cyc + 1});
        last_acc = cyc;
        k++;
      end
      if (abort) begin
        aborted = 1;
        abort_cyc = cyc;
      end
    end
    din_vld = 1'b0; abort = 1'b0;
    if (done_cnt == dstart) $display("FAIL %s_done_timeout: got no done expected done", tag);
    @(negedge clock); @(negedge clock);
    exp_done = aborted ? abort_cyc + 1 : (last_acc >= 0 ? last_acc + 2 : c0 + 2);
    chk({tag, "_done_pulses"}, 32'(done_cnt - dstart), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_accepts"}, 32'(exp_q.size()), 32'(v.exp_wcount));
    chk({tag, "_nwrites"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      wr_t e = exp_q.pop_front();
      wr_t o = obs_q[obs_rd++];
      chk({tag, "_wr_pid"}, 32'(o.pid), 32'(e.pid));
      chk({tag, "_wr_adr"}, 32'(o.adr), 32'(e.adr));
      chk({tag, "_wr_dat"}, 32'(o.dat), 32'(e.dat));
      chk({tag, "_wr_cycle"}, 32'(o.cyc), 32'(e.cyc));
    end
    obs_rd = obs_q.size();
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_err_code"}, 32'(err_code), 32'(v.exp_code));
    chk({tag, "_wcount"}, 32'(wcount), 32'(v.exp_wcount));
    chk({tag, "_checksum"}, 32'(checksum), 32'(v.exp_sum));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    vec_t rv;
    vecs[0]  = '{4'd6,  12'd0,    13'd4,    16'hFFFF, -1, DFLT, 1'b0, 2'd0, 13'd4, 16'd10};
    vecs[1]  = '{4'd5,  12'd0,    13'd4,    16'hFFFF, -1, DFLT, 1'b1, 2'd1, 13'd0, 16'd0};
    vecs[2]  = '{4'd11, 12'd0,    13'd4,    16'hFFFF, -1, DFLT, 1'b1, 2'd1, 13'd0, 16'd0};
    vecs[3]  = '{4'd10, 12'd4094, 13'd3,    16'hFFFF, -1, DFLT, 1'b1, 2'd2, 13'd0, 16'd0};
    vecs[4]  = '{4'd10, 12'd4094, 13'd2,    16'hFFFF, -1,
                 {18'd0, 18'd0, 18'h20005, 18'h10000}, 1'b0, 2'd0, 13'd2, 16'd8};
    vecs[5]  = '{4'd8,  12'h123,  13'd3,    16'h0029, -1,
                 {18'd0, 18'd0, 18'd1, 18'h3FFFF}, 1'b0, 2'd0, 13'd3, 16'h0003};
    vecs[6]  = '{4'd6,  12'd0,    13'd5,    16'hFFFF, 2,
                 {18'd8, 18'd7, 18'd6, 18'd5}, 1'b1, 2'd3, 13'd2, 16'd11};
    vecs[7]  = '{4'd9,  12'd5,    13'd0,    16'hFFFF, -1, DFLT, 1'b0, 2'd0, 13'd0, 16'd0};
    vecs[8]  = '{4'd10, 12'd4095, 13'd1,    16'hFFFF, -1,
                 {18'd0, 18'd0, 18'd0, 18'h2FFFF}, 1'b0, 2'd0, 13'd1, 16'h0001};
    vecs[9]  = '{4'd6,  12'd4095, 13'd2,    16'hFFFF, -1, DFLT, 1'b1, 2'd2, 13'd0, 16'd0};
    vecs[10] = '{4'd15, 12'd4095, 13'd4096, 16'hFFFF, -1, DFLT, 1'b1, 2'd1, 13'd0, 16'd0};
    vecs[11] = '{4'd0,  12'd0,    13'd1,    16'hFFFF, -1, DFLT, 1'b1, 2'd1, 13'd0, 16'd0};

    reset = 1'b1; start = 1'b0; start_pid = '0; start_adr = '0; nwords = '0;
    din = '0; din_vld = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_err", 32'({err, err_code}), 32'd0);
    chk("rst_wcount", 32'(wcount), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_din_rdy", 32'(din_rdy), 32'd0);

    for (int i = 0; i < 12; i++) run_load(vecs[i], i);

    // Abort while CHECK is evaluating the request.
    d0 = done_cnt;
    @(posedge clock); #1;
    start = 1'b1; start_pid = 4'd7; start_adr = 12'd0; nwords = 13'd2;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("chk_abort_done", 32'(done), 32'd1);
    chk("chk_abort_err", 32'({err, err_code}), 32'({1'b1, 2'd3}));
    @(negedge clock);
    chk("chk_abort_nwrites", 32'(obs_q.size() - obs_rd), 32'd0);

    // Abort in IDLE changes nothing.
    d0 = done_cnt;
    @(posedge clock); #1 abort = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done", 32'(done_cnt - d0), 32'd0);
    chk("idle_abort_err", 32'({err, err_code}), 32'({1'b1, 2'd3}));
    @(posedge clock); #1 abort = 1'b0;

    // Reset after one write of a 4-word load.
    d0 = done_cnt;
    @(posedge clock); #1;
    start = 1'b1; start_pid = 4'd6; start_adr = 12'd0; nwords = 13'd4;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    din_vld = 1'b1; din = 18'h11;
    @(negedge clock);
    chk("rml_din_rdy", 32'(din_rdy), 32'd1);
    @(posedge clock); #1;
    din_vld = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("rml_wr_en", 32'(wr_en), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rml_wr_en_off", 32'(wr_en), 32'd0);
    chk("rml_busy", 32'(busy), 32'd0);
    chk("rml_wcount", 32'(wcount), 32'd0);
    repeat (4) @(negedge clock);
    chk("rml_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rml_nwrites", 32'(obs_q.size() - obs_rd), 32'd1);
    obs_rd = obs_q.size();
    rv = '{4'd7, 12'd100, 13'd1, 16'hFFFF, -1,
           {18'd0, 18'd0, 18'd0, 18'h55}, 1'b0, 2'd0, 13'd1, 16'h0055};
    run_load(rv, 99);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
